// File: rtl/spi_master_tx.sv
// spi_master_tx -- SPI master, transmit direction, SCLK idles low.
//
// Frame sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
// SETUP, HOLD and GAP each last CLK_DIV cycles. SHIFT lasts 2*D_Pack*CLK_DIV
// cycles. SCLK rises on the edge that enters SHIFT and then toggles every
// CLK_DIV cycles. The last falling edge is followed by one full low half
// period before HOLD starts.
//
// C_PH=0: the slave samples on rising SCLK. MOSI changes on falling edges.
// C_PH=1: the slave samples on falling SCLK. MOSI changes on rising edges.
//
// Optional feature: define SPI_MASTER_RX_EN to add full-duplex receive
// (MISO, RX_DATA, RX_VALID). MISO is sampled on the same edges the slave uses.
module spi_master_tx #(
    parameter int D_Pack  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [D_Pack-1:0] TX_DATA,
    input  logic              TX_VALID,
    input  logic              C_PH,
    output logic              TX_READY,
    output logic              SCLK,
    output logic              MOSI,
    output logic              CS_N,
    output logic              TX_DONE
`ifdef SPI_MASTER_RX_EN
    ,
    input  logic              MISO,
    output logic [D_Pack-1:0] RX_DATA,
    output logic              RX_VALID
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    // The bit counter runs 0..D_Pack and the divider runs 0..CLK_DIV-1.
    // Both counters are sized so they cannot wrap inside a frame.
    localparam int BW = $clog2(D_Pack) + 1;
    localparam int DW = $clog2(CLK_DIV) + 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(D_Pack);
    localparam logic [BW-1:0] BIT_PEN  = BW'(D_Pack - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [2:0]        state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              cph_q, cph_d;
    logic [D_Pack-1:0] shreg_q, shreg_d;

    logic div_last;
    logic accept;
    logic rise_evt;
    logic fall_evt;
    logic launch_evt;
    logic done_evt;

`ifdef SPI_MASTER_RX_EN
    logic [D_Pack-1:0] rx_shreg_q, rx_shreg_d;
    logic [D_Pack-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              sample_evt;
`endif

    assign TX_READY = ready_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;
    assign CS_N     = cs_n_q;
    assign TX_DONE  = done_q;

    // SCLK edge strobes. Each one is true in the cycle before the CLK edge
    // that moves SCLK. A new bit is launched on the edge opposite to the
    // sampling edge. With C_PH=0 there is no launch after the final bit.
    always_comb begin
        div_last   = (div_q == DIV_LAST);
        accept     = ready_q && TX_VALID;
        rise_evt   = ((state_q == S_SETUP) && div_last) ||
                     ((state_q == S_SHIFT) && div_last && !sclk_q && (bit_q != BIT_LAST));
        fall_evt   = (state_q == S_SHIFT) && div_last && sclk_q;
        done_evt   = (state_q == S_HOLD) && div_last;
        launch_evt = cph_q ? rise_evt : (fall_evt && (bit_q != BIT_PEN));
    end

    // Frame sequencing: state, divider, bit count, SCLK, CS_N, TX_DONE and TX_READY.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        cph_d   = cph_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    state_d = S_SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                    cph_d   = C_PH;
                    cs_n_d  = 1'b0;
                    ready_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (div_last) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (!div_last) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (div_last) begin
                    state_d = S_GAP;
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (div_last) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    bit_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
                ready_d = 1'b0;
            end
        endcase
    end

    // Transmit datapath. With C_PH=0 the MSB goes out at accept and the rest
    // of the word is pre-shifted. With C_PH=1 the MSB waits for the first
    // rising edge. MOSI returns to 0 as CS_N rises.
    always_comb begin
        mosi_d  = mosi_q;
        shreg_d = shreg_q;
        if (accept && (state_q == S_IDLE)) begin
            if (C_PH) begin
                mosi_d  = 1'b0;
                shreg_d = TX_DATA;
            end else begin
                mosi_d  = TX_DATA[D_Pack-1];
                shreg_d = TX_DATA << 1;
            end
        end else if (launch_evt) begin
            mosi_d  = shreg_q[D_Pack-1];
            shreg_d = shreg_q << 1;
        end else if (done_evt) begin
            mosi_d  = 1'b0;
            shreg_d = '0;
        end
    end

    // Register all transmit state. Reset is asynchronous.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            cph_q   <= 1'b0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            cph_q   <= cph_d;
            shreg_q <= shreg_d;
        end
    end

`ifdef SPI_MASTER_RX_EN
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;

    // Capture MISO, MSB first, on the slave's sampling edge. Publish the
    // word in the same cycle that TX_DONE pulses.
    always_comb begin
        sample_evt = cph_q ? fall_evt : rise_evt;
        rx_shreg_d = rx_shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        if (sample_evt) begin
            rx_shreg_d = {rx_shreg_q[D_Pack-2:0], MISO};
        end
        if (done_evt) begin
            rx_data_d  = rx_shreg_q;
            rx_valid_d = 1'b1;
        end
    end

    // Register the receive state. Reset is asynchronous.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_shreg_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_shreg_q <= rx_shreg_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end
`endif

endmodule
